bit_encoder: RTL
================

// Module: bit_encoder
// PURPOSE
//  Transmit side of the comm link. Frames 10-bit words and drives a 14-bit DAC code.
//  Each bit is a 20-tick cell: '1' = falling ramp, '0' = flat plateau.
//  Frame = quiet baseline, START_WORD, N data words, STOP_WORD; every word is sent LSB first.
//  The far-end bit decoder triggers on the first rising edge and samples the slope in each cell.
// PARAMETERS
//  DAC_W        14             DAC code width
//  BASELINE     8192           idle/return level; must stay below the 9216 trigger threshold
//  PULSE_HIGH   12288          cell plateau level; above the trigger threshold
//  SLOPE_STEP   200            per-tick drop during a '1' ramp (8 steps = 1600 > decoder's 700)
//  BIT_TICKS    20             clocks per bit cell
//  QUIET_TICKS  40             baseline clocks before START_WORD; re-arms the receiver trigger
//  START_WORD   10'b0111000111 frame header
//  STOP_WORD    10'b0100110011 frame trailer
// PORTS
//  inclk        in   1      system clock
//  reset_n      in   1      synchronous, active-low reset
//  tx_data      in   10     payload word
//  tx_valid     in   1      tx_data valid / request a frame
//  tx_last      in   1      qualifies tx_data: last payload word of the frame
//  tx_ready     out  1      word accepted on this cycle when tx_valid is also high
//  com_dac      out  DAC_W  registered DAC code
//  bit_strobe   out  1      1-cycle pulse at tick 0 of every transmitted cell
//  busy         out  1      high from leaving IDLE until the return to IDLE
//  tx_err       out  1      1-cycle pulse on underrun or a STOP_WORD alias
// BEHAVIOUR
//  Reset: state=IDLE, com_dac=BASELINE, tx_ready=0, bit_strobe=0, busy=0, tx_err=0, counters=0.
//   Reset wins over all other events. A reset mid-frame aborts it at once; the next cycle drives BASELINE.
//  FSM: IDLE -> QUIET -> START -> DATA -> STOP -> IDLE.
//   IDLE: com_dac=BASELINE. tx_valid=1 -> QUIET next cycle. The word is not consumed.
//   QUIET: holds BASELINE for QUIET_TICKS clocks, then enters START.
//   START/DATA/STOP: each shifts one 10-bit word, bit 0 first, one cell per bit.
//  Cell shaping (tick t = 0..19; com_dac is registered, so 1-cycle latency from t):
//   t=0,1: PULSE_HIGH
//   t=2..9: bit=1 -> PULSE_HIGH - (t-1)*SLOPE_STEP (12088 down to 10688); bit=0 -> PULSE_HIGH
//   t=10..19: BASELINE
//   All arithmetic is unsigned DAC_W-bit. Parameters are chosen so nothing underflows.
//  Word boundary (t=19 of bit 9 in START or DATA):
//   tx_ready=1 for exactly this cycle. It is combinational on state and counters, not on tx_valid.
//   tx_valid=1, tx_data!=STOP_WORD: load word; enter DATA. If tx_last=1, STOP follows this word.
//   tx_valid=1, tx_data==STOP_WORD: consume word, do not send it, pulse tx_err, enter STOP.
//   tx_valid=0: pulse tx_err (underrun), enter STOP.
//   After a word loaded with tx_last=1, no tx_ready at its boundary; enter STOP.
//  STOP: after t=19 of bit 9 -> IDLE. A new frame may begin the following cycle.
//  The cell timing has no gaps: tick 0 of the next cell follows tick 19 with no idle cycle.
//  busy is 0 in IDLE and 1 in every other state.
// STRUCTURE
//  comm_pkg: START_WORD, STOP_WORD, BIT_TICKS, trigger threshold 9216, slope threshold 700, state enum.
//   The decoder and this encoder share these constants.
//  Sub-module bit_cell_shaper: inputs bit and tick; output is the combinational DAC code.
//   The top level registers its output.
//  Top level: FSM, 5-bit tick counter, 4-bit bit counter, 10-bit shift register, handshake.
// TESTING
//  Frame of 1 word (0x2A5, tx_last=1): 40 BASELINE, then START, 0x2A5, STOP cells.
//   Checks: 640 clocks total; busy low afterwards; tx_err=0.
//  Loopback into the bit decoder, 3 words (0x001, 0x3FE, 0x155): decoder reports start, the 3 words,
//   then stop, with each bit matching.
//  Cell levels for a '1': t=2 -> 12088, t=9 -> 10688, t=10 -> 8192.
//   Cell levels for a '0': t=2..9 -> 12288.
//  Underrun: tx_valid drops after word 1. tx_err pulses at the boundary, then STOP_WORD, then IDLE.
//  Alias: a word 0x133 (equal to STOP_WORD) is presented. tx_ready=1, tx_err pulses, only STOP_WORD is sent.
//  Reset: reset_n=0 during DATA bit 4, tick 6. The next cycle gives com_dac=8192, busy=0.
//   A fresh frame afterwards is sent correctly.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared link constants for the bit encoder and the far-end bit decoder.
//   Holds the DAC levels, cell timing, frame words, decoder thresholds and FSM state codes.
package comm_pkg;

   localparam int unsigned DAC_W       = 14;
   localparam int unsigned WORD_W      = 10;
   localparam int unsigned BIT_TICKS   = 20;
   localparam int unsigned QUIET_TICKS = 40;
   // The quiet gap is counted as whole cells so the 5-bit tick counter suffices.
   localparam int unsigned QUIET_CELLS = QUIET_TICKS / BIT_TICKS;
   localparam int unsigned TICK_W      = 5;
   localparam int unsigned BIT_W       = 4;
   localparam int unsigned HIGH_LAST   = 1;   // last tick of the leading plateau
   localparam int unsigned RAMP_LAST   = 9;   // last tick of the slope window

   localparam logic [DAC_W-1:0] BASELINE     = 14'd8192;
   localparam logic [DAC_W-1:0] PULSE_HIGH   = 14'd12288;
   localparam logic [DAC_W-1:0] SLOPE_STEP   = 14'd200;
   localparam logic [DAC_W-1:0] TRIG_THRESH  = 14'd9216;
   localparam logic [DAC_W-1:0] SLOPE_THRESH = 14'd700;

   localparam logic [WORD_W-1:0] START_WORD = 10'b0111000111;
   localparam logic [WORD_W-1:0] STOP_WORD  = 10'b0100110011;

   localparam int unsigned ST_W = 3;
   typedef logic [ST_W-1:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_QUIET = 3'd1;
   localparam state_t ST_START = 3'd2;
   localparam state_t ST_DATA  = 3'd3;
   localparam state_t ST_STOP  = 3'd4;

endpackage

// File: rtl/bit_cell_shaper.sv
// Combinational DAC level for one tick of a bit cell.
//   i_bit    : bit carried by the cell ('1' = falling ramp, '0' = flat plateau)
//   i_tick   : tick within the cell, 0..BIT_TICKS-1
//   o_dac_c  : unregistered DAC code for that tick
module bit_cell_shaper
   import comm_pkg::*;
(
   input  logic              i_bit,
   input  logic [TICK_W-1:0] i_tick,
   output logic [DAC_W-1:0]  o_dac_c
);

   logic [TICK_W-1:0] w_ramp_idx;

   assign w_ramp_idx = i_tick - TICK_W'(1);

   // Plateau, optional ramp (drop of (t-1) steps), then return to baseline.
   always_comb begin
      o_dac_c = BASELINE;
      if (i_tick <= TICK_W'(HIGH_LAST)) begin
         o_dac_c = PULSE_HIGH;
      end else if (i_tick <= TICK_W'(RAMP_LAST)) begin
         o_dac_c = i_bit ? (PULSE_HIGH - DAC_W'(w_ramp_idx) * SLOPE_STEP) : PULSE_HIGH;
      end
   end

endmodule

// File: rtl/bit_encoder.sv
// Transmit side of the comm link: frames 10-bit words into shaped bit cells on a DAC.
//   inclk      : system clock
//   reset_n    : synchronous active-low reset
//   tx_data    : payload word
//   tx_valid   : tx_data valid / request a frame
//   tx_last    : tx_data is the last payload word of the frame
//   tx_ready   : word accepted this cycle when tx_valid is also high (decoded from state)
//   com_dac    : registered DAC code
//   bit_strobe : 1-cycle pulse aligned with tick 0 of each transmitted cell on com_dac
//   busy       : high whenever the encoder is not idle
//   tx_err     : 1-cycle pulse on underrun or a payload word equal to STOP_WORD
module bit_encoder
   import comm_pkg::*;
(
   input  logic              inclk,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   output logic              tx_ready,
   output logic [DAC_W-1:0]  com_dac,
   output logic              bit_strobe,
   output logic              busy,
   output logic              tx_err
);

   state_t            r_state;
   logic [TICK_W-1:0] r_tick;
   logic [BIT_W-1:0]  r_bit;
   logic [WORD_W-1:0] r_shift;
   logic              r_last;

   state_t            w_next_state;
   logic [TICK_W-1:0] w_next_tick;
   logic [BIT_W-1:0]  w_next_bit;
   logic [WORD_W-1:0] w_next_shift;
   logic              w_next_last;
   logic              w_err;
   logic              w_active;
   logic              w_cell_end;
   logic              w_word_end;
   logic [DAC_W-1:0]  w_cell_code;

   assign w_active   = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
   assign w_cell_end = (r_tick == TICK_W'(BIT_TICKS - 1));
   assign w_word_end = w_cell_end && (r_bit == BIT_W'(WORD_W - 1));

   bit_cell_shaper u_shaper (
      .i_bit   (r_shift[0]),
      .i_tick  (r_tick),
      .o_dac_c (w_cell_code)
   );

   // Next-state, counter, shifter and handshake decode.
   always_comb begin
      w_next_state = r_state;
      w_next_tick  = r_tick;
      w_next_bit   = r_bit;
      w_next_shift = r_shift;
      w_next_last  = r_last;
      w_err        = 1'b0;
      tx_ready     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (tx_valid) begin
               w_next_state = ST_QUIET;
               w_next_tick  = '0;
               w_next_bit   = '0;
            end
         end
         ST_QUIET: begin
            w_next_tick = r_tick + TICK_W'(1);
            if (w_cell_end) begin
               w_next_tick = '0;
               w_next_bit  = r_bit + BIT_W'(1);
               if (r_bit == BIT_W'(QUIET_CELLS - 1)) begin
                  w_next_state = ST_START;
                  w_next_bit   = '0;
                  w_next_shift = START_WORD;
                  w_next_last  = 1'b0;
               end
            end
         end
         ST_START, ST_DATA, ST_STOP: begin
            w_next_tick = r_tick + TICK_W'(1);
            if (w_cell_end && !w_word_end) begin
               w_next_tick  = '0;
               w_next_bit   = r_bit + BIT_W'(1);
               w_next_shift = r_shift >> 1;
            end else if (w_word_end) begin
               w_next_tick = '0;
               w_next_bit  = '0;
               if (r_state == ST_STOP) begin
                  w_next_state = ST_IDLE;
               end else if (r_last) begin
                  // Final payload word already sent: no request for another.
                  w_next_state = ST_STOP;
                  w_next_shift = STOP_WORD;
                  w_next_last  = 1'b0;
               end else begin
                  tx_ready = 1'b1;
                  if (tx_valid && (tx_data != STOP_WORD)) begin
                     w_next_state = ST_DATA;
                     w_next_shift = tx_data;
                     w_next_last  = tx_last;
                  end else begin
                     // Underrun or a word that would alias the trailer ends the frame.
                     w_err        = 1'b1;
                     w_next_state = ST_STOP;
                     w_next_shift = STOP_WORD;
                     w_next_last  = 1'b0;
                  end
               end
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_tick  = '0;
            w_next_bit   = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge inclk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_tick     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_last     <= 1'b0;
         com_dac    <= BASELINE;
         bit_strobe <= 1'b0;
         busy       <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_tick     <= w_next_tick;
         r_bit      <= w_next_bit;
         r_shift    <= w_next_shift;
         r_last     <= w_next_last;
         com_dac    <= w_active ? w_cell_code : BASELINE;
         bit_strobe <= w_active && (r_tick == '0);
         busy       <= (w_next_state != ST_IDLE);
         tx_err     <= w_err;
      end
   end

endmodule
